// File: rtl/firstmatch_monitor_pkg.sv
// Shared limits and the saturating-increment helper for the first_match monitor.
package firstmatch_monitor_pkg;

  localparam int MAX_MIN_REP = 15;
  localparam int MAX_DELAY   = 8;
  localparam int MAX_CNT_W   = 32;

  // Increment that holds at all ones of the low 'width' bits (width <= MAX_CNT_W).
  function automatic logic [MAX_CNT_W-1:0] sat_inc(input logic [MAX_CNT_W-1:0] value,
                                                   input int width);
    logic [MAX_CNT_W:0] lim_ext;
    lim_ext = ((MAX_CNT_W+1)'(1) << width) - (MAX_CNT_W+1)'(1);
    return (value == lim_ext[MAX_CNT_W-1:0]) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/firstmatch_monitor_delay_line.sv
// DELAY-deep single-bit shift register with async reset; wire-through when DELAY=0.
module firstmatch_delay_line #(
  parameter int DELAY = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_in,
  output logic o_out
);

  generate
    if (DELAY == 0) begin : g_pass
      logic w_unused_clk_rst;
      assign w_unused_clk_rst = clock | reset;
      assign o_out = i_in;
    end else begin : g_pipe
      logic [DELAY-1:0] r_pipe;
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_pipe <= '0;
        end else begin
          r_pipe[0] <= i_in;
          for (int k = 1; k < DELAY; k++) begin
            r_pipe[k] <= r_pipe[k-1];
          end
        end
      end
      assign o_out = r_pipe[DELAY-1];
    end
  endgenerate

endmodule

// File: rtl/firstmatch_monitor.sv
// Runtime checker for first_match(a ##1 b[*MIN_REP:$] ##1 c) |-> ##DELAY d,
// with match/fail counters and the cycle stamp of the first failure.
module firstmatch_monitor
  import firstmatch_monitor_pkg::*;
#(
  parameter int MIN_REP = 0,
  parameter int DELAY   = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  input  logic             d,
  output logic             match,
  output logic             fail,
  output logic             failed,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] fail_count,
  output logic [CNT_W-1:0] cycle,
  output logic [CNT_W-1:0] first_fail_cycle
);

  // Bit i: some attempt holds exactly i b-repeats; the top bit means ">= MIN_REP".
  logic [MIN_REP:0] r_alive;
  logic [MIN_REP:0] w_alive_nxt;
  logic             w_match;
  logic             w_pipe_out;
  logic             w_fail;

  logic [CNT_W-1:0] r_match_count;
  logic [CNT_W-1:0] r_fail_count;
  logic [CNT_W-1:0] r_cycle;
  logic [CNT_W-1:0] r_first_fail_cycle;
  logic             r_failed;

  logic [MAX_CNT_W-1:0] w_match_inc;
  logic [MAX_CNT_W-1:0] w_fail_inc;
  logic [MAX_CNT_W-1:0] w_cycle_inc;

  generate
    if (MIN_REP == 0) begin : g_rep0
      assign w_alive_nxt = a | (r_alive & b & ~c);
    end else begin : g_repn
      // c retires only the matured threads; younger ones keep climbing on b.
      always_comb begin
        w_alive_nxt    = '0;
        w_alive_nxt[0] = a;
        for (int i = 1; i < MIN_REP; i++) begin
          w_alive_nxt[i] = r_alive[i-1] & b;
        end
        w_alive_nxt[MIN_REP] = (r_alive[MIN_REP-1] & b) | (r_alive[MIN_REP] & b & ~c);
      end
    end
  endgenerate

  assign w_match = r_alive[MIN_REP] & c;

  firstmatch_delay_line #(
    .DELAY(DELAY)
  ) u_delay_line (
    .clock(clock),
    .reset(reset),
    .i_in (w_match),
    .o_out(w_pipe_out)
  );

  assign w_fail = w_pipe_out & ~d;

  assign w_match_inc = sat_inc(MAX_CNT_W'(r_match_count), CNT_W);
  assign w_fail_inc  = sat_inc(MAX_CNT_W'(r_fail_count), CNT_W);
  assign w_cycle_inc = sat_inc(MAX_CNT_W'(r_cycle), CNT_W);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_alive            <= '0;
      r_match_count      <= '0;
      r_fail_count       <= '0;
      r_cycle            <= '0;
      r_first_fail_cycle <= '1;
      r_failed           <= 1'b0;
    end else begin
      r_alive <= w_alive_nxt;
      r_cycle <= CNT_W'(w_cycle_inc);
      if (w_match) begin
        r_match_count <= CNT_W'(w_match_inc);
      end
      if (w_fail) begin
        r_fail_count <= CNT_W'(w_fail_inc);
        if (!r_failed) begin
          r_failed           <= 1'b1;
          r_first_fail_cycle <= r_cycle;
        end
      end
    end
  end

  assign match            = w_match;
  assign fail             = w_fail;
  assign failed           = r_failed;
  assign match_count      = r_match_count;
  assign fail_count       = r_fail_count;
  assign cycle            = r_cycle;
  assign first_fail_cycle = r_first_fail_cycle;

endmodule

// File: tb/tb_firstmatch_monitor.sv
// Bench for firstmatch_monitor: five parameter variants share one stimulus stream.
module tb_firstmatch_monitor;

  localparam int NI   = 5;
  localparam int MAXT = 256;

  function automatic int rep_of(input int k);
    case (k)
      1: return 1;
      4: return 2;
      default: return 0;
    endcase
  endfunction

  function automatic int dly_of(input int k);
    case (k)
      2: return 0;
      3: return 3;
      4: return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int wid_of(input int k);
    return (k == 4) ? 4 : 16;
  endfunction

  function automatic int wmax_of(input int k);
    return (1 << wid_of(k)) - 1;
  endfunction

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic a = 1'b0, b = 1'b0, c = 1'b0, d = 1'b0;
  always #5 clock = ~clock;

  logic obs_m [NI];
  logic obs_f [NI];
  logic obs_fd[NI];
  int   obs_mc[NI];
  int   obs_fc[NI];
  int   obs_cy[NI];
  int   obs_ff[NI];

  for (genvar k = 0; k < NI; k++) begin : g_dut
    localparam int W = wid_of(k);
    logic         w_m, w_f, w_fd;
    logic [W-1:0] w_mc, w_fc, w_cy, w_ff;
    firstmatch_monitor #(
      .MIN_REP(rep_of(k)),
      .DELAY  (dly_of(k)),
      .CNT_W  (W)
    ) u_dut (
      .clock           (clock),
      .reset           (reset),
      .a               (a),
      .b               (b),
      .c               (c),
      .d               (d),
      .match           (w_m),
      .fail            (w_f),
      .failed          (w_fd),
      .match_count     (w_mc),
      .fail_count      (w_fc),
      .cycle           (w_cy),
      .first_fail_cycle(w_ff)
    );
    assign obs_m[k]  = w_m;
    assign obs_f[k]  = w_f;
    assign obs_fd[k] = w_fd;
    assign obs_mc[k] = int'(w_mc);
    assign obs_fc[k] = int'(w_fc);
    assign obs_cy[k] = int'(w_cy);
    assign obs_ff[k] = int'(w_ff);
  end

  int n_vec = 0;
  int n_err = 0;

  // Stimulus history (per trace cycle) and observed outputs.
  bit   ha[MAXT], hb[MAXT], hc[MAXT], hd[MAXT], hr[MAXT];
  int   ep[MAXT];
  logic oh_m [NI][MAXT];
  logic oh_f [NI][MAXT];
  logic oh_fd[NI][MAXT];
  int   oh_mc[NI][MAXT];
  int   oh_fc[NI][MAXT];
  int   oh_cy[NI][MAXT];
  int   oh_ff[NI][MAXT];
  bit   em[NI][MAXT], ef[NI][MAXT];

  // ---------------- driver tasks ----------------
  task automatic clear_hist();
    for (int t = 0; t < MAXT; t++) begin
      ha[t] = 0; hb[t] = 0; hc[t] = 0; hd[t] = 0; hr[t] = 0; ep[t] = 0;
    end
  endtask

  // Reset, then apply trace cycles 0..n-1; trace cycle t is where cycle==t after a clean release.
  task automatic run_trace(input int n);
    reset = 1'b1; a = 0; b = 0; c = 0; d = 0;
    @(posedge clock); #1;
    reset = 1'b0;
    for (int t = 0; t < n; t++) begin
      ep[t] = (t == 0) ? 0 : (hr[t-1] ? t : ep[t-1]);
      reset = hr[t]; a = ha[t]; b = hb[t]; c = hc[t]; d = hd[t];
      @(negedge clock);
      for (int k = 0; k < NI; k++) begin
        oh_m[k][t]  = obs_m[k];
        oh_f[k][t]  = obs_f[k];
        oh_fd[k][t] = obs_fd[k];
        oh_mc[k][t] = obs_mc[k];
        oh_fc[k][t] = obs_fc[k];
        oh_cy[k][t] = obs_cy[k];
        oh_ff[k][t] = obs_ff[k];
      end
      @(posedge clock); #1;
    end
    reset = 1'b0; a = 0; b = 0; c = 0; d = 0;
  endtask

  // ---------------- reference model ----------------
  // An attempt started by a@s matches at t when b held on every cycle in between,
  // it had >= MIN_REP repeats at t, c is high at t, and no earlier c found it mature.
  function automatic bit m_match(input int k, input int t);
    bit ok;
    if (hr[t] || !hc[t]) return 1'b0;
    for (int s = ep[t]; s < t; s++) begin
      if (!ha[s] || (t - 1 - s) < rep_of(k)) continue;
      ok = 1'b1;
      for (int u = s + 1; u < t; u++) begin
        if (!hb[u] || (hc[u] && (u - 1 - s) >= rep_of(k))) ok = 1'b0;
      end
      if (ok) return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic bit m_fail(input int k, input int t);
    int tm;
    if (hr[t]) return 1'b0;
    tm = t - dly_of(k);
    if (tm < ep[t]) return 1'b0;
    return m_match(k, tm) && !hd[t];
  endfunction

  function automatic int sat(input int v, input int k);
    return (v > wmax_of(k)) ? wmax_of(k) : v;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; a = 0; b = 0; c = 0; d = 0;
    @(posedge clock); #1;
    @(negedge clock);
    for (int k = 0; k < NI; k++) begin
      n_vec++; if (obs_m[k] !== 1'b0) begin n_err++; $display("FAIL rst_match k=%0d got %0b want 0", k, obs_m[k]); end
      n_vec++; if (obs_f[k] !== 1'b0) begin n_err++; $display("FAIL rst_fail k=%0d got %0b want 0", k, obs_f[k]); end
      n_vec++; if (obs_fd[k] !== 1'b0) begin n_err++; $display("FAIL rst_failed k=%0d got %0b want 0", k, obs_fd[k]); end
      n_vec++; if (obs_mc[k] !== 0) begin n_err++; $display("FAIL rst_match_count k=%0d got %0d want 0", k, obs_mc[k]); end
      n_vec++; if (obs_fc[k] !== 0) begin n_err++; $display("FAIL rst_fail_count k=%0d got %0d want 0", k, obs_fc[k]); end
      n_vec++; if (obs_cy[k] !== 0) begin n_err++; $display("FAIL rst_cycle k=%0d got %0d want 0", k, obs_cy[k]); end
      n_vec++; if (obs_ff[k] !== wmax_of(k)) begin n_err++; $display("FAIL rst_first_fail k=%0d got %0d want %0d", k, obs_ff[k], wmax_of(k)); end
    end
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    for (int k = 0; k < NI; k++) begin
      n_vec++; if (obs_cy[k] !== 3) begin n_err++; $display("FAIL pre_reset_cycle k=%0d got %0d want 3", k, obs_cy[k]); end
    end
    reset = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_vec++; if (obs_cy[k] !== 0) begin n_err++; $display("FAIL async_reset_cycle k=%0d got %0d want 0", k, obs_cy[k]); end
    end
  endtask

  task automatic build_base(input bit second_a, input bit extra_c);
    clear_hist();
    ha[1] = 1; if (second_a) ha[5] = 1;
    for (int t = 2; t <= 14; t++) hb[t] = 1;
    hc[6] = 1; hc[15] = 1; if (extra_c) hc[11] = 1;
    hd[7] = 1;
  endtask

  task automatic test_single_thread();
    build_base(1'b0, 1'b0);
    run_trace(20);
    for (int t = 0; t < 20; t++) begin
      n_vec++; if (oh_m[0][t] !== (t == 6)) begin n_err++; $display("FAIL s1_match t=%0d got %0b want %0b", t, oh_m[0][t], t == 6); end
      n_vec++; if (oh_f[0][t] !== 1'b0) begin n_err++; $display("FAIL s1_fail t=%0d got %0b want 0", t, oh_f[0][t]); end
    end
    n_vec++; if (oh_mc[0][19] !== 1) begin n_err++; $display("FAIL s1_match_count got %0d want 1", oh_mc[0][19]); end
    n_vec++; if (oh_fd[0][19] !== 1'b0) begin n_err++; $display("FAIL s1_failed got %0b want 0", oh_fd[0][19]); end
  endtask

  task automatic test_merge();
    build_base(1'b1, 1'b1);
    run_trace(20);
    for (int t = 0; t < 20; t++) begin
      n_vec++; if (oh_m[0][t] !== (t == 6)) begin n_err++; $display("FAIL s2_match t=%0d got %0b want %0b", t, oh_m[0][t], t == 6); end
    end
    n_vec++; if (oh_mc[0][19] !== 1) begin n_err++; $display("FAIL s2_match_count got %0d want 1", oh_mc[0][19]); end
    n_vec++; if (oh_fc[0][19] !== 0) begin n_err++; $display("FAIL s2_fail_count got %0d want 0", oh_fc[0][19]); end
  endtask

  task automatic test_min_rep();
    build_base(1'b1, 1'b1);
    run_trace(20);
    for (int t = 0; t < 20; t++) begin
      n_vec++; if (oh_m[1][t] !== (t == 6 || t == 11)) begin n_err++; $display("FAIL s3_match t=%0d got %0b want %0b", t, oh_m[1][t], t == 6 || t == 11); end
      n_vec++; if (oh_f[1][t] !== (t == 12)) begin n_err++; $display("FAIL s3_fail t=%0d got %0b want %0b", t, oh_f[1][t], t == 12); end
    end
    n_vec++; if (oh_fd[1][19] !== 1'b1) begin n_err++; $display("FAIL s3_failed got %0b want 1", oh_fd[1][19]); end
    n_vec++; if (oh_fd[1][12] !== 1'b0) begin n_err++; $display("FAIL s3_failed_early got %0b want 0", oh_fd[1][12]); end
    n_vec++; if (oh_ff[1][19] !== 12) begin n_err++; $display("FAIL s3_first_fail got %0d want 12", oh_ff[1][19]); end
    n_vec++; if (oh_fc[1][19] !== 1) begin n_err++; $display("FAIL s3_fail_count got %0d want 1", oh_fc[1][19]); end
    n_vec++; if (oh_mc[1][19] !== 2) begin n_err++; $display("FAIL s3_match_count got %0d want 2", oh_mc[1][19]); end
    build_base(1'b1, 1'b1);
    hd[12] = 1;
    run_trace(20);
    n_vec++; if (oh_fc[1][19] !== 0) begin n_err++; $display("FAIL s3d_fail_count got %0d want 0", oh_fc[1][19]); end
    n_vec++; if (oh_ff[1][19] !== 16'hffff) begin n_err++; $display("FAIL s3d_first_fail got %0d want 65535", oh_ff[1][19]); end
  endtask

  task automatic test_restart();
    build_base(1'b0, 1'b1);
    ha[6] = 1;
    run_trace(20);
    for (int t = 0; t < 20; t++) begin
      n_vec++; if (oh_m[0][t] !== (t == 6 || t == 11)) begin n_err++; $display("FAIL s4_match t=%0d got %0b want %0b", t, oh_m[0][t], t == 6 || t == 11); end
      n_vec++; if (oh_f[0][t] !== (t == 12)) begin n_err++; $display("FAIL s4_fail t=%0d got %0b want %0b", t, oh_f[0][t], t == 12); end
    end
    n_vec++; if (oh_mc[0][19] !== 2) begin n_err++; $display("FAIL s4_match_count got %0d want 2", oh_mc[0][19]); end
  endtask

  task automatic test_delay();
    build_base(1'b0, 1'b0);
    run_trace(20);
    for (int t = 0; t < 20; t++) begin
      n_vec++; if (oh_f[2][t] !== (t == 6)) begin n_err++; $display("FAIL s5_d0_fail t=%0d got %0b want %0b", t, oh_f[2][t], t == 6); end
    end
    n_vec++; if (oh_ff[2][19] !== 6) begin n_err++; $display("FAIL s5_d0_first_fail got %0d want 6", oh_ff[2][19]); end
    build_base(1'b0, 1'b0);
    hd[9] = 1;
    run_trace(20);
    for (int t = 0; t < 20; t++) begin
      n_vec++; if (oh_f[3][t] !== 1'b0) begin n_err++; $display("FAIL s5_d3_fail t=%0d got %0b want 0", t, oh_f[3][t]); end
    end
    n_vec++; if (oh_mc[3][19] !== 1) begin n_err++; $display("FAIL s5_d3_match_count got %0d want 1", oh_mc[3][19]); end
  endtask

  task automatic test_mid_reset();
    build_base(1'b1, 1'b1);
    hr[8] = 1; hr[9] = 1;
    run_trace(20);
    n_vec++; if (oh_m[1][11] !== 1'b0) begin n_err++; $display("FAIL s6_match11 got %0b want 0", oh_m[1][11]); end
    for (int t = 0; t < 20; t++) begin
      n_vec++; if (oh_f[1][t] !== 1'b0) begin n_err++; $display("FAIL s6_fail t=%0d got %0b want 0", t, oh_f[1][t]); end
    end
    n_vec++; if (oh_mc[1][19] !== 0) begin n_err++; $display("FAIL s6_match_count got %0d want 0", oh_mc[1][19]); end
    n_vec++; if (oh_fc[1][19] !== 0) begin n_err++; $display("FAIL s6_fail_count got %0d want 0", oh_fc[1][19]); end
    n_vec++; if (oh_cy[1][10] !== 0) begin n_err++; $display("FAIL s6_cycle_restart got %0d want 0", oh_cy[1][10]); end
    n_vec++; if (oh_cy[1][19] !== 9) begin n_err++; $display("FAIL s6_cycle_end got %0d want 9", oh_cy[1][19]); end
  endtask

  task automatic test_back_to_back();
    clear_hist();
    for (int t = 1; t <= 8; t++) ha[t] = 1;
    for (int t = 0; t <= 15; t++) hb[t] = 1;
    for (int t = 2; t <= 9; t++) hc[t] = 1;
    run_trace(16);
    for (int t = 0; t < 16; t++) begin
      n_vec++; if (oh_f[0][t] !== (t >= 3 && t <= 10)) begin n_err++; $display("FAIL b2b_d1_fail t=%0d got %0b want %0b", t, oh_f[0][t], t >= 3 && t <= 10); end
      n_vec++; if (oh_f[3][t] !== (t >= 5 && t <= 12)) begin n_err++; $display("FAIL b2b_d3_fail t=%0d got %0b want %0b", t, oh_f[3][t], t >= 5 && t <= 12); end
    end
    n_vec++; if (oh_fc[3][15] !== 8) begin n_err++; $display("FAIL b2b_d3_fail_count got %0d want 8", oh_fc[3][15]); end
    n_vec++; if (oh_mc[1][15] !== 7) begin n_err++; $display("FAIL b2b_rep1_match_count got %0d want 7", oh_mc[1][15]); end
    n_vec++; if (oh_mc[4][15] !== 6) begin n_err++; $display("FAIL b2b_rep2_match_count got %0d want 6", oh_mc[4][15]); end
  endtask

  task automatic test_random();
    int n, xmc, xfc, xcy, xff;
    bit xfd;
    n = 250;
    clear_hist();
    for (int t = 0; t < n; t++) begin
      ha[t] = ($urandom_range(0, 2) == 0);
      hb[t] = ($urandom_range(0, 3) != 0);
      hc[t] = ($urandom_range(0, 2) == 0);
      hd[t] = $urandom_range(0, 1);
      hr[t] = (t > 0) && ($urandom_range(0, 69) == 0);
    end
    run_trace(n);
    for (int k = 0; k < NI; k++) begin
      for (int t = 0; t < n; t++) begin
        em[k][t] = m_match(k, t);
        ef[k][t] = m_fail(k, t);
      end
    end
    for (int k = 0; k < NI; k++) begin
      for (int t = 0; t < n; t++) begin
        xmc = 0; xfc = 0; xcy = 0; xff = wmax_of(k); xfd = 0;
        if (!hr[t]) begin
          for (int u = ep[t]; u < t; u++) begin
            xmc += em[k][u];
            xfc += ef[k][u];
            if (ef[k][u] && !xfd) begin xfd = 1; xff = sat(u - ep[t], k); end
          end
          xmc = sat(xmc, k); xfc = sat(xfc, k); xcy = sat(t - ep[t], k);
        end
        n_vec++; if (oh_m[k][t] !== em[k][t]) begin n_err++; $display("FAIL rnd_match k=%0d t=%0d got %0b want %0b", k, t, oh_m[k][t], em[k][t]); end
        n_vec++; if (oh_f[k][t] !== ef[k][t]) begin n_err++; $display("FAIL rnd_fail k=%0d t=%0d got %0b want %0b", k, t, oh_f[k][t], ef[k][t]); end
        n_vec++; if (oh_fd[k][t] !== xfd) begin n_err++; $display("FAIL rnd_failed k=%0d t=%0d got %0b want %0b", k, t, oh_fd[k][t], xfd); end
        n_vec++; if (oh_mc[k][t] !== xmc) begin n_err++; $display("FAIL rnd_match_count k=%0d t=%0d got %0d want %0d", k, t, oh_mc[k][t], xmc); end
        n_vec++; if (oh_fc[k][t] !== xfc) begin n_err++; $display("FAIL rnd_fail_count k=%0d t=%0d got %0d want %0d", k, t, oh_fc[k][t], xfc); end
        n_vec++; if (oh_cy[k][t] !== xcy) begin n_err++; $display("FAIL rnd_cycle k=%0d t=%0d got %0d want %0d", k, t, oh_cy[k][t], xcy); end
        n_vec++; if (oh_ff[k][t] !== xff) begin n_err++; $display("FAIL rnd_first_fail k=%0d t=%0d got %0d want %0d", k, t, oh_ff[k][t], xff); end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_thread();
    test_merge();
    test_min_rep();
    test_restart();
    test_delay();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/firstmatch_monitor.md
Name: firstmatch_monitor

Overview:
Synthesizable runtime checker for the property first_match(a ##1 b[*MIN_REP:$] ##1 c) |-> ##DELAY d.
- Sits directly downstream of the trace sequencer stage and consumes its a/b/c/d outputs.
- Gives an RTL-visible pass/fail result that is cross-checked against the formal assertion on the same traces.
- Tracks overlapping attempts. Counts matches and failures. Records the cycle of the first failure.

Parameters:
MIN_REP, 0, minimum consecutive b repetitions (0 gives b[*], 1 gives b[+]); legal range 0..15
DELAY, 1, cycles from match to the d check (1 gives |=>, 0 gives |->); legal range 0..8
CNT_W, 16, width of the cycle counter and the event counters

Ports:
clock  input  1  sampling clock; all state updates on its rising edge
reset  input  1  asynchronous, active-high reset; clears all state
a  input  1  sequence start condition
b  input  1  repetition condition
c  input  1  sequence end condition
d  input  1  consequent, checked DELAY cycles after a match
match  output  1  pulse in the cycle where a first_match completes (c sampled)
fail  output  1  pulse in the cycle where the consequent check fails
failed  output  1  sticky; set by the first fail
match_count  output  CNT_W  saturating count of match pulses
fail_count  output  CNT_W  saturating count of fail pulses
cycle  output  CNT_W  saturating count of clock edges since reset release
first_fail_cycle  output  CNT_W  value of cycle when the first fail occurred; all ones until then

Behaviour:
- Reset (asynchronous, active-high): clear thread vector, match pipeline and all counters; failed=0; first_fail_cycle=all ones. All outputs combinationally valid right after reset.
- Thread vector alive[MIN_REP:0]: bit i marks at least one pending attempt with exactly i b-repetitions; bit MIN_REP means >=MIN_REP. Attempts with equal repetition count are indistinguishable and merge.
- Combinational: match = alive[MIN_REP] & c.
- Next state, MIN_REP=0: alive[0]' = a | (alive[0] & b & ~c).
- Next state, MIN_REP>0:
  - alive[0]' = a
  - alive[i]' = alive[i-1] & b, for 1 <= i < MIN_REP
  - alive[MIN_REP]' = (alive[MIN_REP-1] & b) | (alive[MIN_REP] & b & ~c)
- first_match rule: c terminates only the threads that have matched (bit MIN_REP). Younger threads with fewer repetitions continue if b holds.
- A new start in the same cycle as a match is independent; a restarts a thread even if one is already pending.
- Consequent, DELAY=0: fail = match & ~d, same cycle.
- Consequent, DELAY>0: match enters a DELAY-deep shift register; fail = pipe_out & ~d. Back-to-back matches are each checked.
- Counters:
  - match_count and fail_count increment on their pulses and saturate at all ones.
  - cycle increments every clock and saturates.
  - On the first fail, failed<=1 and first_fail_cycle<=cycle (the current value, registered). Later fails do not update it.
- Reset mid-operation discards all pending attempts and queued checks. No fail is reported for them.
- Inputs are sampled only at rising edges of clock; no X filtering.

Decomposition:
- Shared package: MAX_MIN_REP=15, MAX_DELAY=8, and a helper function for the saturating increment.
- One natural sub-module, firstmatch_delay_line: parameterised DELAY-deep single-bit shift register with async reset. It passes its input straight through when DELAY=0.

Test Plan:
1. MIN_REP=0, DELAY=1; a@1, b@2..14, c@6,15, d@7 -> match@6 only (c@15 ignored), fail never, match_count=1.
2. As 1 with a@1,5 and c@6,11,15 -> both threads merge, single match@6, d@7 satisfies, fail_count=0.
3. As 2 with MIN_REP=1 -> thread from a@5 not matched at c@6, matches@11; d missing @12 -> fail@12, failed=1, first_fail_cycle=12, fail_count=1. Repeating with an added d@12 -> fail_count=0.
4. MIN_REP=0, a@1,6, b@2..14, c@6,11,15, d@7 -> match@6 and match@11, fail@12, match_count=2.
5. Scenario 1 with DELAY=0 -> fail@6 (d absent @6); with DELAY=3 and d@9 -> no fail.
6. Scenario 3 with reset pulsed @8..9 -> no match@11, no fail, all counters 0, cycle restarts from 0 after release.
